// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: feeds one 28x28 frame into the CNN model, drains its logits and argmaxes them.
// Optional cycle counter output perf_cycles is enabled by defining CNN_FRAME_SEQUENCER_PERF_EN.
module cnn_frame_sequencer #(
   parameter int VALUE_BITS   = 18,
   parameter int N            = 12,
   parameter int PIXEL_BITS   = 8,
   parameter int FRAME_PIXELS = 784,
   parameter int NUM_CLASSES  = 10
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   output logic                              busy,
   input  logic [PIXEL_BITS-1:0]             src_data,
   input  logic                              src_valid,
   output logic                              src_ready,
   output logic [VALUE_BITS-1:0]             m_data,
   output logic                              m_valid,
   output logic                              m_last,
   input  logic                              m_ready,
   input  logic [VALUE_BITS*NUM_CLASSES-1:0] s_data,
   input  logic                              s_valid,
   input  logic                              s_last,
   output logic                              s_ready,
   output logic [3:0]                        res_class,
   output logic [VALUE_BITS-1:0]             res_score,
   output logic                              res_valid,
   input  logic                              res_ready
`ifdef CNN_FRAME_SEQUENCER_PERF_EN
   ,
   output logic [31:0]                       perf_cycles
`endif
);

   localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
   localparam int IDX_W = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_WAIT_OUT,
      S_ARGMAX,
      S_DONE
   } state_t;

   state_t                        state, state_nx;
   logic [CNT_W-1:0]              pix_cnt;
   logic                          last_seen;
   logic signed [VALUE_BITS-1:0]  logit [NUM_CLASSES];
   logic [IDX_W-1:0]              idx;
   logic [IDX_W-1:0]              best_idx;
   logic signed [VALUE_BITS-1:0]  best;

   logic                          last_pix;
   logic                          src_xfer;
   logic                          s_cap;
   logic                          enter_argmax;

   assign last_pix = (pix_cnt == CNT_W'(FRAME_PIXELS - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      busy         = 1'b1;
      src_ready    = 1'b0;
      m_valid      = 1'b0;
      m_last       = 1'b0;
      m_data       = '0;
      s_ready      = 1'b0;
      res_valid    = 1'b0;
      src_xfer     = 1'b0;
      s_cap        = 1'b0;
      enter_argmax = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nx = S_STREAM;
         end
         S_STREAM: begin
            src_ready = m_ready;
            m_valid   = src_valid;
            m_last    = last_pix;
            m_data    = VALUE_BITS'(src_data) << (N - PIXEL_BITS);
            s_ready   = 1'b1;
            src_xfer  = src_valid & m_ready;
            s_cap     = s_valid & s_last;
            // An s_last beat seen during streaming (or on the final pixel cycle) skips WAIT_OUT
            if (src_xfer && last_pix) begin
               if (last_seen || s_cap) begin
                  state_nx     = S_ARGMAX;
                  enter_argmax = 1'b1;
               end else begin
                  state_nx = S_WAIT_OUT;
               end
            end
         end
         S_WAIT_OUT: begin
            s_ready = 1'b1;
            s_cap   = s_valid & s_last;
            if (s_cap) begin
               state_nx     = S_ARGMAX;
               enter_argmax = 1'b1;
            end
         end
         S_ARGMAX: begin
            if (idx == IDX_W'(NUM_CLASSES - 1)) state_nx = S_DONE;
         end
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_cnt   <= '0;
         last_seen <= 1'b0;
         idx       <= '0;
         best_idx  <= '0;
         best      <= '0;
         for (int unsigned c = 0; c < NUM_CLASSES; c++) logit[c] <= '0;
      end else begin
         if (state == S_IDLE && start) begin
            pix_cnt   <= '0;
            last_seen <= 1'b0;
         end
         if (src_xfer && !last_pix) pix_cnt <= pix_cnt + CNT_W'(1);
         if (s_cap) begin
            last_seen <= 1'b1;
            for (int unsigned c = 0; c < NUM_CLASSES; c++)
               logit[c] <= s_data[c*VALUE_BITS +: VALUE_BITS];
         end
         // Seed from the live bus when the capture and the ARGMAX entry share a cycle
         if (enter_argmax) begin
            idx      <= IDX_W'(1);
            best_idx <= '0;
            best     <= s_cap ? $signed(s_data[VALUE_BITS-1:0]) : logit[0];
         end else if (state == S_ARGMAX) begin
            if (logit[idx] > best) begin
               best     <= logit[idx];
               best_idx <= idx;
            end
            idx <= idx + IDX_W'(1);
         end
      end
   end

   assign res_class = best_idx;
   assign res_score = best;

`ifdef CNN_FRAME_SEQUENCER_PERF_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_cnt <= '0;
      else if (state == S_IDLE && start)
         stall_cnt <= '0;
      else if (state != S_IDLE && state != S_DONE && stall_cnt != '1)
         stall_cnt <= stall_cnt + 32'd1;
   end

   assign perf_cycles = stall_cnt;
`endif

endmodule
